// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick once every BIT_CYCLES clocks while en is high,
// and holds at zero while en is low so every enable starts a fresh period.
module uart_baud_tick #(
  parameter int BIT_CYCLES = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the end of each bit period, clear when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8 data bits LSB first, one parity bit, one stop bit,
// with a one-entry holding register so a second byte can queue behind the frame.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000,
  parameter int BAUDRATE   = 10000,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int   BIT_CYCLES = CLK_FREQ / BAUDRATE;
  localparam logic PAR_ODD    = (PARITY_ODD != 0);

  if (BIT_CYCLES < 2) begin : g_cfg_check
    $error("uart_tx_ctrl: CLK_FREQ/BAUDRATE must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 bit_tick;
  logic                 handshake;
  logic                 frame_load;
  logic                 from_hold;
  logic                 to_hold;
  logic [DATA_BITS-1:0] load_byte;

  uart_baud_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .en   (state_q != IDLE),
    .tick (bit_tick)
  );

  assign handshake  = valid && ready_q;
  assign from_hold  = (state_q == STOP) && bit_tick && hold_full_q;
  // A new frame starts from IDLE, or back-to-back at the final STOP cycle.
  assign frame_load = ((state_q == IDLE) && handshake) ||
                      ((state_q == STOP) && bit_tick && (hold_full_q || handshake));
  assign to_hold    = handshake && !frame_load;
  assign load_byte  = from_hold ? hold_q : data_in;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake) state_d = START;
        else           state_d = IDLE;
      end
      START: begin
        if (bit_tick) state_d = DATA;
        else          state_d = START;
      end
      DATA: begin
        if (bit_tick && (idx_q == 3'(DATA_BITS - 1))) state_d = PARITY;
        else                                          state_d = DATA;
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
        else          state_d = PARITY;
      end
      STOP: begin
        if (bit_tick) begin
          if (hold_full_q || handshake) state_d = START;
          else                          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: shifter, bit index, parity and holding register.
  always_comb begin
    shift_d     = shift_q;
    idx_d       = idx_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (frame_load) begin
      shift_d = load_byte;
      par_d   = parity_bit(load_byte, PAR_ODD);
      idx_d   = 3'd0;
    end else if ((state_q == DATA) && bit_tick) begin
      shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
      idx_d   = idx_q + 3'd1;
    end else begin
      shift_d = shift_q;
    end
    if (to_hold) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else if (from_hold) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // Output decode from the upcoming state so tx/busy/ready leave flops.
  always_comb begin
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    ready_d = ~hold_full_d;
    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = shift_d[0];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = par_d;
        busy_d = 1'b1;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      idx_q       <= 3'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table of single bytes, plus back-to-back,
// blocked third byte and mid-frame reset sequences; a line monitor checks frames.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data_in;
  logic       ready, tx, busy;
  logic       ready_odd, tx_odd, busy_odd;

  int n_checks    = 0;
  int n_fail      = 0;
  int frames_seen = 0;
  int frames_exp  = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       exp_par_even;
    logic       exp_par_odd;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  uart_tx_ctrl dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy)
  );

  uart_tx_ctrl #(.PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready_odd), .tx(tx_odd), .busy(busy_odd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit accepted);
    @(negedge clk);
    data_in  = b;
    valid    = 1'b1;
    accepted = (ready === 1'b1);
    if (accepted) begin
      sb.push_back(b);
      frames_exp++;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Line monitor: captures 11 bits x 5 clocks from each start bit on the even-parity DUT.
  initial begin : line_monitor
    logic       s [0:54];
    int         i;
    bit         aborted;
    bit         stable;
    logic [7:0] got;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        s[0]    = tx;
        aborted = 1'b0;
        i       = 1;
        while (i < 55 && !aborted) begin
          @(negedge clk);
          if (reset !== 1'b0) aborted = 1'b1;
          else s[i] = tx;
          i++;
        end
        if (!aborted) begin
          frames_seen++;
          stable = 1'b1;
          for (int b = 0; b < 11; b++)
            for (int c = 1; c < 5; c++)
              if (s[b*5+c] !== s[b*5]) stable = 1'b0;
          check("bit_stable", {31'd0, stable}, 32'd1);
          for (int j = 0; j < 8; j++) got[j] = s[(1+j)*5];
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got data %0h, expected no frame", got);
          end else begin
            exp_b = sb.pop_front();
            check("frame_data", {24'd0, got}, {24'd0, exp_b});
            check("frame_parity", {31'd0, s[45]}, {31'd0, ^exp_b});
            check("frame_stop", {31'd0, s[50]}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit acc;
    bit busy_ok;
    bit third_ok;

    vecs[0] = '{8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 1'b0, 1'b1};

    reset   = 1'b1;
    valid   = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_ready", {31'd0, ready}, 32'd1);

    // Single frames from IDLE.
    for (int v = 0; v < 7; v++) begin
      send_byte(vecs[v].data, acc);
      check("accept", {31'd0, acc}, 32'd1);
      busy_ok = 1'b1;
      for (int k = 0; k < 55; k++) begin
        @(negedge clk);
        if (k == 0) begin
          check("start_tx", {31'd0, tx}, 32'd0);
          check("start_busy", {31'd0, busy}, 32'd1);
          check("start_ready", {31'd0, ready}, 32'd1);
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (k == 47) begin
          check("par_even", {31'd0, tx}, {31'd0, vecs[v].exp_par_even});
          check("par_odd", {31'd0, tx_odd}, {31'd0, vecs[v].exp_par_odd});
        end
      end
      check("busy_55", {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_tx", {31'd0, tx}, 32'd1);
    end

    // Back-to-back 0x55 then 0xF0, third byte blocked by the full holding register.
    send_byte(8'h55, acc);
    check("b2b_acc1", {31'd0, acc}, 32'd1);
    send_byte(8'hF0, acc);
    check("b2b_acc2", {31'd0, acc}, 32'd1);
    @(negedge clk);
    check("b2b_ready_low", {31'd0, ready}, 32'd0);
    data_in  = 8'h33;
    valid    = 1'b1;
    third_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ready !== 1'b0) third_ok = 1'b0;
    end
    valid = 1'b0;
    check("third_blocked", {31'd0, third_ok}, 32'd1);
    busy_ok = 1'b1;
    for (int k = 12; k < 55; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("b2b_busy1", {31'd0, busy_ok}, 32'd1);
    check("b2b_stop1", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("b2b_start2", {31'd0, tx}, 32'd0);
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    check("b2b_ready_back", {31'd0, ready}, 32'd1);
    repeat (55) @(negedge clk);
    check("b2b_idle", {31'd0, busy}, 32'd0);
    check("b2b_sb_empty", sb.size(), 32'd0);

    // Reset during DATA bit 3 of 0xFF.
    send_byte(8'hFF, acc);
    check("rst_acc", {31'd0, acc}, 32'd1);
    for (int k = 0; k < 22; k++) @(negedge clk);
    check("rst_pre_tx", {31'd0, tx}, 32'd1);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    frames_exp--;
    send_byte(8'h00, acc);
    check("post_acc", {31'd0, acc}, 32'd1);
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      if (k == 0)  check("post_start", {31'd0, tx}, 32'd0);
      if (k == 47) check("post_par", {31'd0, tx}, 32'd0);
    end
    @(negedge clk);
    check("post_idle", {31'd0, busy}, 32'd0);

    check("frame_count", frames_seen, frames_exp);
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
